// File: rtl/pll_pkg.sv
// Shared types, default gain codes and helpers for the pll supervisory logic.
package pll_pkg;

  localparam int unsigned ERR_W_DEF = 8;
  localparam int unsigned SHIFT_W   = 4;

  localparam logic [SHIFT_W-1:0] ACQ_KP_DEF = 4'd2;
  localparam logic [SHIFT_W-1:0] ACQ_KI_DEF = 4'd4;
  localparam logic [SHIFT_W-1:0] TRK_KP_DEF = 4'd4;
  localparam logic [SHIFT_W-1:0] TRK_KI_DEF = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_ILLEGAL = 2'd3
  } pll_state_e;

  typedef struct packed {
    logic [SHIFT_W-1:0] kp;
    logic [SHIFT_W-1:0] ki;
  } pll_gain_t;

  // |x| for a w-bit signed value carried in 32 bits; the most-negative code saturates.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned w);
    logic signed [31:0] most_neg;
    most_neg = -(32'sd1 <<< (w - 1));
    if (x == most_neg) return 32'((32'sd1 <<< (w - 1)) - 32'sd1);
    else if (x < 0)    return 32'(-x);
    return 32'(x);
  endfunction

endpackage

// File: rtl/pll_err_window.sv
// Phase-error magnitude window: saturating |err| against the lock and unlock thresholds.
module pll_err_window
  import pll_pkg::*;
#(
  parameter int unsigned ERR_W         = ERR_W_DEF,
  parameter int unsigned LOCK_THRESH   = 8,
  parameter int unsigned UNLOCK_THRESH = 16
) (
  input  logic signed [ERR_W-1:0] i_err,
  output logic                    o_in_win_c,
  output logic                    o_out_win_c
);

  logic [ERR_W-1:0] abs_c;

  always_comb begin
    abs_c       = ERR_W'(sat_abs(32'(i_err), ERR_W));
    o_in_win_c  = (32'(abs_c) <= LOCK_THRESH);
    o_out_win_c = (32'(abs_c) >  UNLOCK_THRESH);
  end

endmodule

// File: rtl/pll_loop_ctrl.sv
// Pll acquisition/tracking supervisor with lock hysteresis and gain sequencing.
// Define PLL_LOOP_CTRL_STATS_EN to add the o_loss_cnt unlock-event counter.
module pll_loop_ctrl
  import pll_pkg::*;
#(
  parameter int unsigned        ERR_W         = ERR_W_DEF,
  parameter int unsigned        LOCK_THRESH   = 8,
  parameter int unsigned        UNLOCK_THRESH = 16,
  parameter int unsigned        LOCK_CNT      = 16,
  parameter int unsigned        UNLOCK_CNT    = 4,
  parameter int unsigned        TIMEOUT       = 1024,
  parameter logic [SHIFT_W-1:0] ACQ_KP        = ACQ_KP_DEF,
  parameter logic [SHIFT_W-1:0] ACQ_KI        = ACQ_KI_DEF,
  parameter logic [SHIFT_W-1:0] TRK_KP        = TRK_KP_DEF,
  parameter logic [SHIFT_W-1:0] TRK_KI        = TRK_KI_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic                    i_err_valid,
  input  logic signed [ERR_W-1:0] i_err,
  output logic [SHIFT_W-1:0]      o_kp_shift,
  output logic [SHIFT_W-1:0]      o_ki_shift,
  output logic                    o_gain_upd,
  output logic                    o_locked,
  output logic                    o_timeout,
  output logic [1:0]              o_state
`ifdef PLL_LOOP_CTRL_STATS_EN
  ,
  output logic [7:0]              o_loss_cnt
`endif
);

  localparam int unsigned LOCK_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned UNL_W  = $clog2(UNLOCK_CNT + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  localparam pll_gain_t GAIN_ACQ = '{kp: ACQ_KP, ki: ACQ_KI};
  localparam pll_gain_t GAIN_TRK = '{kp: TRK_KP, ki: TRK_KI};

  pll_state_e        state_q, state_d;
  pll_gain_t         gain_q, gain_d;
  logic              gain_upd_q, gain_upd_d;
  logic              locked_q, locked_d;
  logic              timeout_q, timeout_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d, lock_inc;
  logic [UNL_W-1:0]  unl_cnt_q, unl_cnt_d, unl_inc;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic              in_win_c, out_win_c;
`ifdef PLL_LOOP_CTRL_STATS_EN
  logic [7:0]        loss_q, loss_d;
`endif

  pll_err_window #(
    .ERR_W         (ERR_W),
    .LOCK_THRESH   (LOCK_THRESH),
    .UNLOCK_THRESH (UNLOCK_THRESH)
  ) u_err_window (
    .i_err       (i_err),
    .o_in_win_c  (in_win_c),
    .o_out_win_c (out_win_c)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      gain_q     <= GAIN_ACQ;
      gain_upd_q <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
      lock_cnt_q <= '0;
      unl_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
`ifdef PLL_LOOP_CTRL_STATS_EN
      loss_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      gain_upd_q <= gain_upd_d;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
      lock_cnt_q <= lock_cnt_d;
      unl_cnt_q  <= unl_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
`ifdef PLL_LOOP_CTRL_STATS_EN
      loss_q     <= loss_d;
`endif
    end
  end

  // Next state, counters and registered outputs; i_enable=0 overrides any sample.
  always_comb begin
    state_d    = state_q;
    gain_d     = gain_q;
    gain_upd_d = 1'b0;
    locked_d   = locked_q;
    timeout_d  = 1'b0;
    lock_cnt_d = lock_cnt_q;
    unl_cnt_d  = unl_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
`ifdef PLL_LOOP_CTRL_STATS_EN
    loss_d     = loss_q;
`endif
    lock_inc = (lock_cnt_q == LOCK_W'(LOCK_CNT))  ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);
    unl_inc  = (unl_cnt_q  == UNL_W'(UNLOCK_CNT)) ? unl_cnt_q  : unl_cnt_q  + UNL_W'(1);
    tmo_inc  = (tmo_cnt_q  == TMO_W'(TIMEOUT))    ? tmo_cnt_q  : tmo_cnt_q  + TMO_W'(1);

    if (!i_enable || state_q == ST_ILLEGAL) begin
      state_d    = ST_IDLE;
      locked_d   = 1'b0;
      gain_d     = GAIN_ACQ;
      gain_upd_d = (gain_q != GAIN_ACQ);
      lock_cnt_d = '0;
      unl_cnt_d  = '0;
      tmo_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_ACQUIRE;
          gain_d     = GAIN_ACQ;
          locked_d   = 1'b0;
          lock_cnt_d = '0;
          unl_cnt_d  = '0;
          tmo_cnt_d  = '0;
        end
        ST_ACQUIRE: begin
          if (i_err_valid) begin
            lock_cnt_d = in_win_c ? lock_inc : '0;
            tmo_cnt_d  = tmo_inc;
            // Lock takes precedence over a timeout landing on the same sample.
            if (in_win_c && lock_inc == LOCK_W'(LOCK_CNT)) begin
              state_d    = ST_TRACK;
              locked_d   = 1'b1;
              gain_d     = GAIN_TRK;
              gain_upd_d = 1'b1;
              lock_cnt_d = '0;
              tmo_cnt_d  = '0;
            end else if (tmo_inc == TMO_W'(TIMEOUT)) begin
              timeout_d  = 1'b1;
              lock_cnt_d = '0;
              tmo_cnt_d  = '0;
            end
          end
        end
        ST_TRACK: begin
          if (i_err_valid) begin
            unl_cnt_d = out_win_c ? unl_inc : '0;
            if (out_win_c && unl_inc == UNL_W'(UNLOCK_CNT)) begin
              state_d    = ST_ACQUIRE;
              locked_d   = 1'b0;
              gain_d     = GAIN_ACQ;
              gain_upd_d = 1'b1;
              lock_cnt_d = '0;
              unl_cnt_d  = '0;
              tmo_cnt_d  = '0;
`ifdef PLL_LOOP_CTRL_STATS_EN
              if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`endif
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign o_kp_shift = gain_q.kp;
  assign o_ki_shift = gain_q.ki;
  assign o_gain_upd = gain_upd_q;
  assign o_locked   = locked_q;
  assign o_timeout  = timeout_q;
  assign o_state    = state_q;
`ifdef PLL_LOOP_CTRL_STATS_EN
  assign o_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// Scoreboard bench for pll_loop_ctrl: directed samples queue expected outputs per cycle.
module tb_pll_loop_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              vld;
  logic signed [7:0] err;
  logic [3:0]        o_kp_shift, o_ki_shift;
  logic              o_gain_upd, o_locked, o_timeout;
  logic [1:0]        o_state;
`ifdef PLL_LOOP_CTRL_STATS_EN
  logic [7:0]        o_loss_cnt;
`endif

  pll_loop_ctrl dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_enable    (en),
    .i_err_valid (vld),
    .i_err       (err),
    .o_kp_shift  (o_kp_shift),
    .o_ki_shift  (o_ki_shift),
    .o_gain_upd  (o_gain_upd),
    .o_locked    (o_locked),
    .o_timeout   (o_timeout),
    .o_state     (o_state)
`ifdef PLL_LOOP_CTRL_STATS_EN
    ,
    .o_loss_cnt  (o_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] e_loss = 8'd0;

  typedef struct {
    int          cyc;
    logic [20:0] v;
    string       tag;
  } exp_t;

  exp_t q[$];

  function automatic logic [7:0] loss_now();
`ifdef PLL_LOOP_CTRL_STATS_EN
    return o_loss_cnt;
`else
    return 8'd0;
`endif
  endfunction

  function automatic logic [7:0] want_loss();
`ifdef PLL_LOOP_CTRL_STATS_EN
    return e_loss;
`else
    return 8'd0;
`endif
  endfunction

  function automatic logic [20:0] got_vec();
    return {o_kp_shift, o_ki_shift, o_gain_upd, o_locked, o_timeout, o_state, loss_now()};
  endfunction

  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got kp=%0d ki=%0d gu=%0b lk=%0b tmo=%0b st=%0d loss=%0d, want kp=%0d ki=%0d gu=%0b lk=%0b tmo=%0b st=%0d loss=%0d",
               tag, cyc, got[20:17], got[16:13], got[12], got[11], got[10], got[9:8], got[7:0],
               want[20:17], want[16:13], want[12], want[11], want[10], want[9:8], want[7:0]);
    end
  endtask

  // Monitor: compare queued expectations on their cycle; any unclaimed pulse is an error.
  always @(negedge clk) begin : mon
    bit matched;
    matched = 1'b0;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", q[0].tag, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    while (q.size() > 0 && q[0].cyc == cyc) begin
      chk(q[0].tag, got_vec(), q[0].v);
      void'(q.pop_front());
      matched = 1'b1;
    end
    if (!matched && (o_gain_upd === 1'b1 || o_timeout === 1'b1)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_pulse @cyc %0d: gu=%0b tmo=%0b, want both 0", cyc, o_gain_upd, o_timeout);
    end
  end

  task automatic step(input logic e, input logic v, input logic signed [7:0] x);
    @(negedge clk);
    en  = e;
    vld = v;
    err = x;
  endtask

  // n valid samples of x, each preceded (except the first) by gap idle cycles.
  task automatic feed(input int n, input logic signed [7:0] x, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) step(1'b1, 1'b0, x);
      step(1'b1, 1'b1, x);
    end
  endtask

  // Expected outputs after the clock edge that consumes the inputs just driven.
  task automatic expect_out(input string tag, input logic [3:0] kp, input logic [3:0] ki,
                            input logic gu, input logic lk, input logic tmo, input logic [1:0] st);
    exp_t e;
    e.cyc = cyc + 1;
    e.v   = {kp, ki, gu, lk, tmo, st, want_loss()};
    e.tag = tag;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    vld   = 1'b0;
    err   = 8'sd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    step(1'b0, 1'b0, 8'sd0);  expect_out("reset_idle", 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 8'sd0);  expect_out("enter_acq",  4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd1);

    feed(15, 8'sd3, 0);       expect_out("acq_15x3",   4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd1);
    feed(1, 8'sd3, 0);        expect_out("lock1",      4'd4, 4'd8, 1'b1, 1'b1, 1'b0, 2'd2);
    step(1'b1, 1'b0, 8'sd0);  expect_out("lock1_gu1",  4'd4, 4'd8, 1'b0, 1'b1, 1'b0, 2'd2);

    feed(3, 8'sd17, 0);
    feed(1, 8'sd16, 0);       expect_out("trk_16_clr", 4'd4, 4'd8, 1'b0, 1'b1, 1'b0, 2'd2);
    feed(3, -8'sd17, 0);      expect_out("trk_3x-17",  4'd4, 4'd8, 1'b0, 1'b1, 1'b0, 2'd2);
    feed(1, -8'sd17, 0);
    e_loss = 8'd1;            expect_out("unlock1",    4'd2, 4'd4, 1'b1, 1'b0, 1'b0, 2'd1);
    step(1'b1, 1'b0, 8'sd0);  expect_out("unlock1_gu1",4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd1);

    feed(15, 8'sd3, 5);
    feed(1, 8'sd9, 0);        expect_out("acq_p9",     4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd1);
    feed(15, -8'sd8, 5);      expect_out("acq_15x-8",  4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd1);
    feed(1, -8'sd8, 0);       expect_out("lock2",      4'd4, 4'd8, 1'b1, 1'b1, 1'b0, 2'd2);

    feed(3, 8'sh80, 0);       expect_out("trk_3xm128", 4'd4, 4'd8, 1'b0, 1'b1, 1'b0, 2'd2);
    feed(1, 8'sh80, 0);
    e_loss = 8'd2;            expect_out("unlock_m128",4'd2, 4'd4, 1'b1, 1'b0, 1'b0, 2'd1);

    for (int i = 0; i < 1023; i++) step(1'b1, 1'b1, (i % 3 == 0) ? 8'sh80 : 8'sd50);
    expect_out("tmo_1023",    4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd1);
    feed(1, 8'sd50, 0);       expect_out("timeout",    4'd2, 4'd4, 1'b0, 1'b0, 1'b1, 2'd1);
    step(1'b1, 1'b0, 8'sd0);  expect_out("timeout_end",4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd1);

    feed(1008, 8'sd50, 0);
    feed(15, 8'sd3, 0);       expect_out("tie_pre",    4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd1);
    feed(1, 8'sd3, 0);        expect_out("tie_lock",   4'd4, 4'd8, 1'b1, 1'b1, 1'b0, 2'd2);
    step(1'b1, 1'b0, 8'sd0);  expect_out("tie_gu1",    4'd4, 4'd8, 1'b0, 1'b1, 1'b0, 2'd2);

    step(1'b0, 1'b1, 8'sd3);  expect_out("endrop_trk", 4'd2, 4'd4, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 8'sd0);  expect_out("idle_hold",  4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 8'sd0);  expect_out("reacq",      4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd1);
    feed(4, 8'sd3, 0);
    step(1'b0, 1'b1, 8'sd3);  expect_out("endrop_acq", 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd0);

    step(1'b1, 1'b0, 8'sd0);  expect_out("reacq2",     4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd1);
    feed(16, 8'sd3, 0);       expect_out("lock3",      4'd4, 4'd8, 1'b1, 1'b1, 1'b0, 2'd2);
    feed(4, 8'sd17, 0);
    e_loss = 8'd3;            expect_out("unlock3",    4'd2, 4'd4, 1'b1, 1'b0, 1'b0, 2'd1);
    step(1'b0, 1'b0, 8'sd0);  expect_out("idle_keep",  4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 8'sd0);  expect_out("reacq3",     4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd1);
    feed(16, 8'sd3, 0);       expect_out("lock4",      4'd4, 4'd8, 1'b1, 1'b1, 1'b0, 2'd2);

    // Reset lands while the lock4 gain_upd pulse is still high.
    @(negedge clk);
    #2 rst_n = 1'b0;
    en  = 1'b0;
    vld = 1'b0;
    #1 chk("async_reset", got_vec(), {4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0});
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    e_loss = 8'd0;
    step(1'b0, 1'b0, 8'sd0);  expect_out("post_reset", 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 2'd0);

    repeat (3) @(negedge clk);
    #1;
    while (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", q[0].tag, q[0].cyc);
      void'(q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
